// File: rtl/edge_detect_stream_px_if.sv
`timescale 1ns/1ps
// Avalon-ST link used on both sides of the edge detector.
// master drives the beat, slave returns backpressure.
interface edge_detect_stream_px_if #(
    parameter int DW = 24
);
    logic [DW-1:0] data;
    logic          startofpacket;
    logic          endofpacket;
    logic          valid;
    logic          ready;

    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/edge_detect_stream_px.sv
`timescale 1ns/1ps
// Inline Avalon-ST edge detector: grayscale plus causal 3x3 Sobel, with
// mode/threshold/width shadowed per frame and non-video packets passed through.
module edge_detect_stream_px #(
    parameter int BPC            = 8,
    parameter int MAX_WIDTH      = 640,
    parameter int DEFAULT_WIDTH  = 320,
    parameter int DEFAULT_THRESH = 64
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset,
    input  logic [1:0]  edge_detection_control_slave_address,
    input  logic        edge_detection_control_slave_write_n,
    input  logic [31:0] edge_detection_control_slave_writedata,
    input  logic        edge_detection_control_slave_chipselect,
    output logic [31:0] edge_detection_control_slave_readdata,
    edge_detect_stream_px_if.slave  video_stream_sink,
    edge_detect_stream_px_if.master video_stream_source
);
    localparam int DW = 3 * BPC;
    localparam int SW = BPC + 4;
    localparam int CW = $clog2(MAX_WIDTH);

    typedef logic [BPC+7:0]       gray_t;
    typedef logic signed [SW-1:0] sob_t;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        wr_en;
    logic [15:0] wr_width;

    assign clk      = sys_clk_clk;
    assign rst      = sys_reset_reset;
    assign addr     = edge_detection_control_slave_address;
    assign wd       = edge_detection_control_slave_writedata;
    assign wr_en    = edge_detection_control_slave_chipselect && !edge_detection_control_slave_write_n;
    assign wr_width = (wd[15:0] == 16'd0 || wd[15:0] > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : wd[15:0];

    logic [1:0]     mode_r, mode_sh;
    logic [BPC-1:0] thresh_r, thresh_sh;
    logic [15:0]    width_r, width_sh, frames_r;
    logic [15:0]    col, row;
    logic           in_video;

    always_comb begin
        edge_detection_control_slave_readdata = '0;
        case (addr)
            2'd0:    edge_detection_control_slave_readdata[1:0]     = mode_r;
            2'd1:    edge_detection_control_slave_readdata[BPC-1:0] = thresh_r;
            2'd2:    edge_detection_control_slave_readdata[15:0]    = frames_r;
            default: edge_detection_control_slave_readdata[15:0]    = width_r;
        endcase
    end

    logic advance, accept, sop_in, eop_in, hdr_video, pkt_video, pix_in;

    assign advance   = !video_stream_source.valid || video_stream_source.ready;
    assign video_stream_sink.ready = advance;
    assign accept    = video_stream_sink.valid && advance;
    assign sop_in    = video_stream_sink.startofpacket;
    assign eop_in    = video_stream_sink.endofpacket;
    assign hdr_video = (video_stream_sink.data[3:0] == 4'h0);
    assign pkt_video = sop_in ? hdr_video : in_video;
    assign pix_in    = accept && !sop_in && in_video;

    gray_t          y_full;
    logic [BPC-1:0] y_in;

    assign y_full = gray_t'(77)  * gray_t'(video_stream_sink.data[DW-1 -: BPC])
                  + gray_t'(150) * gray_t'(video_stream_sink.data[2*BPC-1 -: BPC])
                  + gray_t'(29)  * gray_t'(video_stream_sink.data[BPC-1:0]);
    assign y_in   = y_full[BPC+7:8];

    // lb1 holds the previous row, lb0 the one before it, both indexed by column
    logic [BPC-1:0] lb0 [MAX_WIDTH];
    logic [BPC-1:0] lb1 [MAX_WIDTH];
    logic [BPC-1:0] win [3][3];
    logic [CW-1:0]  lb_idx;
    logic [BPC-1:0] up1, up2;

    assign lb_idx = col[CW-1:0];
    assign up1    = lb1[lb_idx];
    assign up2    = lb0[lb_idx];

    always_ff @(posedge clk) begin
        if (pix_in && !rst) begin
            lb0[lb_idx] <= up1;
            lb1[lb_idx] <= y_in;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= up2;
            win[1][2] <= up1;
            win[2][2] <= y_in;
        end
    end

    logic           s1_valid, s1_sop, s1_eop, s1_pix, s1_border;
    logic [DW-1:0]  s1_data;
    logic [BPC-1:0] s1_y;

    // The window already holds the pixel sitting in stage 1, so Sobel is formed here
    function automatic sob_t ext(input logic [BPC-1:0] v);
        return sob_t'({4'b0000, v});
    endfunction

    sob_t           gx, gy;
    logic [SW-1:0]  ax, ay;
    logic [SW:0]    msum;
    logic [BPC-1:0] mag, m_eff;
    logic [DW-1:0]  pix_out;

    assign gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    assign gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    assign ax    = gx[SW-1] ? -gx : gx;
    assign ay    = gy[SW-1] ? -gy : gy;
    assign msum  = {1'b0, ax} + {1'b0, ay};
    assign mag   = (|msum[SW:BPC]) ? '1 : msum[BPC-1:0];
    assign m_eff = s1_border ? '0 : mag;

    always_comb begin
        pix_out = s1_data;
        case (mode_sh)
            2'd1:    pix_out = {3{s1_y}};
            2'd2:    pix_out = {3{m_eff}};
            2'd3:    pix_out = (m_eff >= thresh_sh) ? '1 : '0;
            default: pix_out = s1_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= 2'd0;
            thresh_r  <= BPC'(DEFAULT_THRESH);
            width_r   <= 16'(DEFAULT_WIDTH);
            frames_r  <= 16'd0;
            mode_sh   <= 2'd0;
            thresh_sh <= '0;
            width_sh  <= 16'd0;
            col       <= 16'd0;
            row       <= 16'd0;
            in_video  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_pix    <= 1'b0;
            s1_border <= 1'b1;
            s1_data   <= '0;
            s1_y      <= '0;
            video_stream_source.valid         <= 1'b0;
            video_stream_source.startofpacket <= 1'b0;
            video_stream_source.endofpacket   <= 1'b0;
            video_stream_source.data          <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    2'd0:    mode_r   <= wd[1:0];
                    2'd1:    thresh_r <= wd[BPC-1:0];
                    2'd3:    width_r  <= wr_width;
                    default: ;
                endcase
            end

            if (wr_en && addr == 2'd2)
                frames_r <= 16'd0;
            else if (accept && pkt_video && eop_in)
                frames_r <= frames_r + 16'd1;

            if (accept && sop_in) begin
                in_video <= hdr_video;
                if (hdr_video) begin
                    mode_sh   <= mode_r;
                    thresh_sh <= thresh_r;
                    width_sh  <= width_r;
                    col       <= 16'd0;
                    row       <= 16'd0;
                end
            end
            if (accept && eop_in)
                in_video <= 1'b0;

            if (pix_in) begin
                if (col == width_sh - 16'd1) begin
                    col <= 16'd0;
                    if (row != 16'hFFFF)
                        row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end

            if (advance) begin
                s1_valid  <= video_stream_sink.valid;
                s1_sop    <= sop_in;
                s1_eop    <= eop_in;
                s1_pix    <= pix_in;
                s1_border <= (row < 16'd2) || (col < 16'd2);
                s1_data   <= video_stream_sink.data;
                s1_y      <= y_in;
                video_stream_source.valid         <= s1_valid;
                video_stream_source.startofpacket <= s1_sop;
                video_stream_source.endofpacket   <= s1_eop;
                video_stream_source.data          <= s1_pix ? pix_out : s1_data;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wd[31:16], y_full[7:0]};
endmodule

// File: tb/tb_edge_detect_stream_px.sv
`timescale 1ns/1ps
// Bench for edge_detect_stream_px: directed and random frames scored against
// a frame-level grayscale/Sobel reference model.
module tb_edge_detect_stream_px;
    localparam int BPC  = 8;
    localparam int DW   = 24;
    localparam int MAXW = 640;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] wdata = '0;
    logic        cs = 1'b0;
    logic [31:0] rdata;

    edge_detect_stream_px_if #(.DW(DW)) snk ();
    edge_detect_stream_px_if #(.DW(DW)) src ();

    edge_detect_stream_px #(
        .BPC(BPC), .MAX_WIDTH(MAXW), .DEFAULT_WIDTH(320), .DEFAULT_THRESH(64)
    ) dut (
        .sys_clk_clk                            (clk),
        .sys_reset_reset                        (rst),
        .edge_detection_control_slave_address   (addr),
        .edge_detection_control_slave_write_n   (write_n),
        .edge_detection_control_slave_writedata (wdata),
        .edge_detection_control_slave_chipselect(cs),
        .edge_detection_control_slave_readdata  (rdata),
        .video_stream_sink                      (snk),
        .video_stream_source                    (src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic rdy_rand = 1'b0;
    logic lat_chk = 1'b1;
    logic mon_en = 1'b1;

    logic [1:0]  m_mode = 2'd0;
    logic [7:0]  m_thresh = 8'd64;
    logic [15:0] m_width = 16'd320;
    logic [15:0] m_frames = 16'd0;

    beat_t       exp_q[$];
    int          pres_q[$];
    logic [23:0] pkt[$];
    int          ys_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int gray(input logic [23:0] p);
        int v;
        v = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return v / 256;
    endfunction

    // dr = rows above the current pixel, dc = columns to its left
    function automatic int yat(input int idx, input int w, input int dr, input int dc);
        return ys_q[idx - dr * w - dc];
    endfunction

    function automatic int sobel(input int idx, input int w);
        int gx, gy, m;
        gx = (yat(idx, w, 2, 0) + 2 * yat(idx, w, 1, 0) + yat(idx, w, 0, 0))
           - (yat(idx, w, 2, 2) + 2 * yat(idx, w, 1, 2) + yat(idx, w, 0, 2));
        gy = (yat(idx, w, 0, 2) + 2 * yat(idx, w, 0, 1) + yat(idx, w, 0, 0))
           - (yat(idx, w, 2, 2) + 2 * yat(idx, w, 2, 1) + yat(idx, w, 2, 0));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        src.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            src.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial forever begin
        beat_t e;
        int pc;
        @(negedge clk);
        if (mon_en && src.valid && src.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat: observed %h expected none", src.data);
            end else begin
                e  = exp_q.pop_front();
                pc = (pres_q.size() != 0) ? pres_q.pop_front() : -100;
                chk("out_data", 32'(src.data), 32'(e.data));
                chk("out_sop", 32'(src.startofpacket), 32'(e.sop));
                chk("out_eop", 32'(src.endofpacket), 32'(e.eop));
                if (lat_chk) chk("latency", 32'(cyc - pc), 32'd2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        addr = a; wdata = d; cs = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        snk.data = d; snk.startofpacket = s; snk.endofpacket = e; snk.valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = snk.ready;
            if (acc) pres_q.push_back(cyc);
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 1000) begin
                checks++;
                errors++;
                $error("FAIL sink_timeout: observed ready=0 expected ready=1");
                break;
            end
        end
        snk.valid = 1'b0;
    endtask

    // Expected output is computed for the whole packet from the register
    // values in force when its SOP goes in; wr_at optionally writes MODE mid-packet.
    task automatic send_pkt(input int wr_at, input logic [1:0] wr_mode);
        int n, w;
        logic vid;
        logic [1:0] md;
        logic [7:0] th;
        beat_t b;
        n   = pkt.size();
        vid = (pkt[0][3:0] == 4'h0);
        w   = int'(m_width);
        md  = m_mode;
        th  = m_thresh;
        ys_q.delete();
        for (int k = 0; k < n; k++) begin
            b.data = pkt[k];
            b.sop  = (k == 0);
            b.eop  = (k == n - 1);
            if (vid && k > 0) begin
                int idx, r, c, y, m;
                idx = k - 1;
                r = idx / w;
                c = idx % w;
                y = gray(pkt[k]);
                ys_q.push_back(y);
                m = (r >= 2 && c >= 2) ? sobel(idx, w) : 0;
                case (md)
                    2'd1: b.data = {3{8'(y)}};
                    2'd2: b.data = {3{8'(m)}};
                    2'd3: b.data = (m >= int'(th)) ? 24'hFFFFFF : 24'h0;
                    default: ;
                endcase
            end
            exp_q.push_back(b);
        end
        for (int k = 0; k < n; k++) begin
            if (k == wr_at) begin
                wr(2'd0, 32'(wr_mode));
                m_mode = wr_mode;
            end
            send_beat(pkt[k], k == 0, k == n - 1);
        end
        if (vid) m_frames++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [1:0] md, input logic [7:0] th, input logic [15:0] w);
        wr(2'd0, 32'(md));
        wr(2'd1, 32'(th));
        wr(2'd3, 32'(w));
        m_mode = md; m_thresh = th; m_width = w;
    endtask

    task automatic new_pkt(input logic [23:0] hdr);
        pkt.delete();
        pkt.push_back(hdr);
    endtask

    initial begin
        logic [23:0] mask;
        logic [1:0]  md;
        int          w;
        logic [15:0] fr_before;

        snk.valid = 1'b0; snk.data = '0; snk.startofpacket = 1'b0; snk.endofpacket = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_src_valid", 32'(src.valid), 0);
        chk("rst_src_data", 32'(src.data), 0);
        chk("rst_src_sop", 32'(src.startofpacket), 0);
        chk("rst_sink_ready", 32'(snk.ready), 1);
        rd_chk("rst_mode", 2'd0, 0);
        rd_chk("rst_thresh", 2'd1, 64);
        rd_chk("rst_frames", 2'd2, 0);
        rd_chk("rst_width", 2'd3, 320);

        // bypass 2x4
        set_regs(2'd0, 8'd64, 16'd4);
        new_pkt(24'h0);
        for (int i = 0; i < 8; i++) pkt.push_back(24'($urandom));
        send_pkt(-1, 2'd0);
        drain();
        rd_chk("bypass_frames", 2'd2, 32'(m_frames));

        // gray, early EOP after two pixels
        set_regs(2'd1, 8'd64, 16'd4);
        new_pkt(24'h0);
        pkt.push_back({8'd200, 8'd100, 8'd50});
        pkt.push_back(24'hFFFFFF);
        send_pkt(-1, 2'd0);
        drain();

        // magnitude: white right half over three rows
        set_regs(2'd2, 8'd64, 16'd4);
        new_pkt(24'h0);
        for (int i = 0; i < 12; i++) pkt.push_back((i % 4 >= 2) ? 24'hFFFFFF : 24'h0);
        send_pkt(-1, 2'd0);
        drain();

        // threshold just above and exactly at M=40
        for (int t = 0; t < 2; t++) begin
            set_regs(2'd3, (t == 0) ? 8'd50 : 8'd40, 16'd4);
            new_pkt(24'h0);
            for (int i = 0; i < 12; i++) pkt.push_back((i % 4 >= 2) ? 24'h0A0A0A : 24'h0);
            send_pkt(-1, 2'd0);
            drain();
        end

        // random frames under 50% downstream backpressure
        rdy_rand = 1'b1;
        lat_chk  = 1'b0;
        for (int f = 0; f < 7; f++) begin
            md = 2'($urandom_range(0, 3));
            w  = $urandom_range(3, 7);
            set_regs(md, 8'($urandom_range(10, 200)), 16'(w));
            if (f == 2) begin
                drain();
                fr_before = m_frames;
                new_pkt(24'($urandom) | 24'hF);
                pkt.push_back(24'($urandom));
                pkt.push_back(24'($urandom));
                send_pkt(-1, 2'd0);
                drain();
                rd_chk("ctrl_frames", 2'd2, 32'(fr_before));
            end
            mask = ($urandom_range(0, 1) == 1) ? 24'h3F3F3F : 24'hFFFFFF;
            new_pkt(24'($urandom) & 24'hFFFFF0);
            for (int i = 0; i < w * 3 + int'($urandom_range(0, 4)); i++)
                pkt.push_back(24'($urandom) & mask);
            send_pkt((f == 3) ? 5 : -1, md + 2'd1);
        end
        drain();
        rd_chk("rand_frames", 2'd2, 32'(m_frames));
        rd_chk("midframe_mode", 2'd0, 32'(m_mode));

        // reset part-way through a frame
        rdy_rand = 1'b0;
        lat_chk  = 1'b1;
        set_regs(2'd1, 8'd64, 16'd4);
        mon_en = 1'b0;
        send_beat(24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(24'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pres_q.delete();
        m_mode = 2'd0; m_thresh = 8'd64; m_width = 16'd320; m_frames = 16'd0;
        chk("midrst_valid", 32'(src.valid), 0);
        chk("midrst_sink_ready", 32'(snk.ready), 1);
        rd_chk("midrst_frames", 2'd2, 0);
        rd_chk("midrst_mode", 2'd0, 0);
        rd_chk("midrst_width", 2'd3, 320);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_output", 32'(src.valid), 0);
        mon_en = 1'b1;

        set_regs(2'd2, 8'd64, 16'd3);
        new_pkt(24'h0);
        for (int i = 0; i < 9; i++) pkt.push_back(24'($urandom));
        send_pkt(-1, 2'd0);
        drain();
        rd_chk("post_rst_frames", 2'd2, 1);

        // width clamping and FRAMES clear
        wr(2'd3, 32'd0);
        rd_chk("width_zero", 2'd3, MAXW);
        wr(2'd3, 32'd1000);
        rd_chk("width_big", 2'd3, MAXW);
        wr(2'd3, 32'd640);
        rd_chk("width_max", 2'd3, 640);
        wr(2'd3, 32'd639);
        rd_chk("width_639", 2'd3, 639);
        wr(2'd2, 32'd123);
        rd_chk("frames_clear", 2'd2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/edge_detect_stream_px.md
Name: edge_detect_stream_px

Overview:
- Parametrised successor to the Edge Detection Subsystem. Sits inline on the Avalon-ST video pipe between the frame source and the video output.
- Converts RGB to grayscale and computes a causal 3x3 Sobel magnitude using two on-chip line buffers.
- Four modes are selected at runtime over the control slave: bypass, gray, magnitude and binary threshold.
- Line width is programmable up to MAX_WIDTH. Non-video (control) packets pass through untouched.

Parameters:
- BPC, 8, bits per colour channel. DW = 3*BPC; R occupies the MSBs, B the LSBs.
- MAX_WIDTH, 640, line buffer depth in pixels. Also the maximum programmable width.
- DEFAULT_WIDTH, 320, reset value of the WIDTH register.
- DEFAULT_THRESH, 64, reset value of the THRESH register.

Ports:
- sys_clk_clk  in  1  single clock.
- sys_reset_reset  in  1  synchronous, active-high reset.
- edge_detection_control_slave_address  in  2  register select.
- edge_detection_control_slave_write_n  in  1  active-low write strobe.
- edge_detection_control_slave_writedata  in  32  write data.
- edge_detection_control_slave_chipselect  in  1  slave select.
- edge_detection_control_slave_readdata  out  32  read data.
- video_stream_sink_data  in  DW  input pixel.
- video_stream_sink_startofpacket / _endofpacket / _valid  in  1 each  Avalon-ST sink qualifiers.
- video_stream_sink_ready  out  1  sink backpressure.
- video_stream_source_ready  in  1  downstream ready.
- video_stream_source_data  out  DW  output pixel.
- video_stream_source_startofpacket / _endofpacket / _valid  out  1 each  Avalon-ST source qualifiers.

Behaviour:
- Registers. A write occurs when chipselect=1 and write_n=0. readdata is a combinational mux on address.
  - 0 MODE[1:0], reset 0: 0 bypass, 1 gray, 2 magnitude, 3 threshold.
  - 1 THRESH[BPC-1:0].
  - 2 FRAMES[15:0]: read-only count of video packets completed. Any write clears it.
  - 3 WIDTH[15:0]: a written value of 0 or a value above MAX_WIDTH is clamped to MAX_WIDTH.
  - Unused readdata bits read 0.
- Shadowing. MODE, THRESH and WIDTH are copied to shadow registers on the SOP beat of a video packet. A mid-frame write takes effect at the next frame only.
- Packet type.
  - Data[3:0] of the SOP beat selects the type; 0 marks a video packet. The SOP beat itself is always forwarded unmodified.
  - Beats of non-video packets are forwarded unmodified. They do not touch the counters, line buffers or FRAMES.
- Pipeline.
  - Two register stages; advance = !source_valid || source_ready; sink_ready = advance.
  - An accepted beat appears on the source exactly 2 advancing cycles later, with sop/eop delayed alongside it. No beat is dropped or duplicated.
  - When advance=0, all stages, counters and line-buffer writes hold.
- Counters.
  - col and row reset to 0 on each accepted video beat after SOP whose predecessor was SOP. The first pixel is (0,0).
  - col increments per accepted pixel. At col=WIDTH-1 it wraps to 0 and row increments; row saturates at 0xFFFF.
- Grayscale: Y = (77*R + 150*G + 29*B) >> 8, computed with BPC+8-bit intermediates. Y always fits BPC bits.
- Line buffers.
  - lb1 holds row r-1 and lb0 holds row r-2, both indexed by col.
  - Per pixel: read both at col, write lb0<=lb1[col] and lb1<=Y.
  - A 3-column shift register per row forms window w[i][j], where i=0 is the oldest row and j=2 is the newest column.
- Sobel (causal; window bottom-right = current pixel).
  - Gx = (w0,2 + 2*w1,2 + w2,2) - (w0,0 + 2*w1,0 + w2,0).
  - Gy = (w2,0 + 2*w2,1 + w2,2) - (w0,0 + 2*w0,1 + w0,2).
  - Use signed BPC+4 bits; M = |Gx| + |Gy|, saturated to 2^BPC-1.
  - When row<2 or col<2, M=0.
- Output per mode, for video pixels only:
  - bypass: input pixel unchanged.
  - gray: {Y,Y,Y}.
  - magnitude: {M,M,M}.
  - threshold: all-ones if M>=THRESH, else 0.
- End of frame.
  - An EOP beat on a video packet increments FRAMES on acceptance; FRAMES wraps at 0xFFFF->0.
  - An early or late EOP relative to WIDTH is tolerated; counters re-zero at the next SOP.
- Reset.
  - Clears source_valid/sop/eop, pipeline valids, counters, FRAMES and shadows. Registers return to their defaults.
  - source_data resets to 0 and sink_ready to 1 (since advance=1).
  - Line buffer contents are undefined after reset; the border rule masks them.
  - Reset mid-frame drops in-flight beats with no partial output.

Test Plan:
- Bypass: MODE=0, WIDTH=4, 2x4 frame with arbitrary pixels, source_ready=1 -> identical beats, sop/eop preserved, valid 2 cycles after each input; FRAMES reads 1.
- Gray: MODE=1, pixel (200,100,50) -> source_data 0x7C7C7C; (255,255,255) -> 0xFFFFFF.
- Magnitude: MODE=2, WIDTH=4, 3 rows each 0,0,255,255 (white) -> rows 0-1 all 0; row 2 = 0,0,0xFFFFFF,0xFFFFFF (Gx=1020 saturates).
- Threshold: MODE=3, gray columns 0,0,10,10 over 3 rows gives M=40. THRESH=50 -> row 2 col2/3 = 0; THRESH=40 -> 0xFFFFFF.
- Backpressure and control packets: random source_ready at 50% -> output stream identical to the ready=1 run. A control packet (SOP data[3:0]=0xF, 3 beats) mid-stream -> forwarded verbatim, FRAMES unchanged. A MODE write mid-frame -> applies from the next SOP.
- Reset: assert sys_reset_reset for 1 cycle mid-frame -> source_valid=0 next cycle, FRAMES=0, MODE reads 0, WIDTH reads DEFAULT_WIDTH. A subsequent frame is processed correctly. WIDTH write of 0 reads back MAX_WIDTH.
